// File: rtl/ascon_aead_seq_pkg.sv
// Shared state encoding and block geometry for the ASCON job sequencer.
package ascon_aead_seq_pkg;

  localparam int BLK_BYTES_DEF = 16;
  localparam int LEN_W_DEF     = 32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_AD_REQ,
    S_AD_RUN,
    S_MSG_REQ,
    S_MSG_RUN,
    S_MSG_CAP,
    S_MSG_OUT,
    S_FINAL,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/ascon_seq_pos.sv
// Byte position within the current phase plus the "this is the last block" flag.
// Latency: pos updates one cycle after clr/inc; last is combinational; no backpressure.
module ascon_seq_pos #(
  parameter int LEN_W     = 32,
  parameter int BLK_BYTES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] pos,
  output logic             last
);

  // One extra bit so pos+BLK_BYTES near the top of the range cannot wrap.
  logic [LEN_W:0] pos_next;

  assign pos_next = {1'b0, pos} + (LEN_W+1)'(BLK_BYTES);
  assign last     = pos_next >= {1'b0, len};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pos <= '0;
    end else if (inc) begin
      pos <= pos_next[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/ascon_aead_seq.sv
// Runs one ASCON AEAD job (init, AD, text, final) over the core strobes; 2-cycle core pass per block.
// Waits with all strobes low while s_valid or m_ready is held off; core_err aborts with a failed tag pulse.
module ascon_aead_seq
  import ascon_aead_seq_pkg::*;
#(
  parameter int BLK_BYTES = BLK_BYTES_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_sel_type,
  input  logic             cfg_decrypt,
  input  logic [LEN_W-1:0] cfg_ad_len,
  input  logic [LEN_W-1:0] cfg_msg_len,
  input  logic [127:0]     cfg_exp_tag,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [127:0]     s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     m_data,
  output logic             m_last,
  output logic             busy,
  output logic             tag_valid,
  output logic [127:0]     tag_out,
  output logic             tag_ok,
  output logic             error,
  output logic             core_en_init,
  output logic             core_en_ad,
  output logic             core_en_ed,
  output logic             core_en_final,
  output logic             core_en_hash,
  output logic [1:0]       core_sel_type,
  output logic             core_mode,
  output logic [LEN_W-1:0] core_len,
  output logic [LEN_W-1:0] core_pos,
  output logic [127:0]     core_data_in,
  input  logic [127:0]     core_data_out,
  input  logic [127:0]     core_tag,
  input  logic             core_done,
  input  logic             core_err
);

  seq_state_t       state;
  logic [1:0]       sel_r;
  logic             dec_r;
  logic [LEN_W-1:0] ad_len_r, msg_len_r, pos;
  logic [127:0]     exp_tag_r, blk_reg, out_reg;
  logic             en_init, en_ad, en_ed, en_final;
  logic             in_msg, abort, pos_clr, pos_inc, pos_last;

  assign in_msg  = state inside {S_MSG_REQ, S_MSG_RUN, S_MSG_CAP, S_MSG_OUT};
  assign abort   = core_err && (en_init || en_ad || en_ed || en_final);
  assign pos_clr = !abort && ((state == S_INIT) ||
                              (state == S_AD_RUN && core_done && pos_last));
  assign pos_inc = !abort && ((state == S_AD_RUN && core_done && !pos_last) ||
                              (state == S_MSG_OUT && m_ready && !pos_last));

  ascon_seq_pos #(.LEN_W(LEN_W), .BLK_BYTES(BLK_BYTES)) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pos_clr),
    .inc   (pos_inc),
    .len   (core_len),
    .pos   (pos),
    .last  (pos_last)
  );

  assign core_en_init  = en_init;
  assign core_en_ad    = en_ad;
  assign core_en_ed    = en_ed;
  assign core_en_final = en_final;
  assign core_en_hash  = 1'b0;
  assign core_sel_type = sel_r;
  assign core_mode     = dec_r;
  assign core_len      = in_msg ? msg_len_r : ad_len_r;
  assign core_pos      = pos;
  assign core_data_in  = blk_reg;
  assign m_data        = out_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sel_r     <= '0;
      dec_r     <= 1'b0;
      ad_len_r  <= '0;
      msg_len_r <= '0;
      exp_tag_r <= '0;
      blk_reg   <= '0;
      out_reg   <= '0;
      en_init   <= 1'b0;
      en_ad     <= 1'b0;
      en_ed     <= 1'b0;
      en_final  <= 1'b0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      tag_valid <= 1'b0;
      tag_out   <= '0;
      tag_ok    <= 1'b0;
      error     <= 1'b0;
    end else begin
      tag_valid <= 1'b0;
      if (abort) begin
        en_init   <= 1'b0;
        en_ad     <= 1'b0;
        en_ed     <= 1'b0;
        en_final  <= 1'b0;
        s_ready   <= 1'b0;
        m_valid   <= 1'b0;
        m_last    <= 1'b0;
        error     <= 1'b1;
        tag_ok    <= 1'b0;
        tag_valid <= 1'b1;
        state     <= S_DONE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            sel_r     <= cfg_sel_type;
            dec_r     <= cfg_decrypt;
            ad_len_r  <= cfg_ad_len;
            msg_len_r <= cfg_msg_len;
            exp_tag_r <= cfg_exp_tag;
            error     <= 1'b0;
            tag_ok    <= 1'b0;
            busy      <= 1'b1;
            en_init   <= 1'b1;
            state     <= S_INIT;
          end
          S_INIT: begin
            en_init <= 1'b0;
            // Empty AD still gets one pass with zero data and no s beat.
            if (ad_len_r == '0) begin
              blk_reg <= '0;
              en_ad   <= 1'b1;
              state   <= S_AD_RUN;
            end else begin
              s_ready <= 1'b1;
              state   <= S_AD_REQ;
            end
          end
          S_AD_REQ: if (s_valid) begin
            blk_reg <= s_data;
            s_ready <= 1'b0;
            en_ad   <= 1'b1;
            state   <= S_AD_RUN;
          end
          S_AD_RUN: if (core_done) begin
            en_ad <= 1'b0;
            if (!pos_last) begin
              s_ready <= 1'b1;
              state   <= S_AD_REQ;
            end else if (msg_len_r == '0) begin
              blk_reg <= '0;
              en_ed   <= 1'b1;
              state   <= S_MSG_RUN;
            end else begin
              s_ready <= 1'b1;
              state   <= S_MSG_REQ;
            end
          end
          S_MSG_REQ: if (s_valid) begin
            blk_reg <= s_data;
            s_ready <= 1'b0;
            en_ed   <= 1'b1;
            state   <= S_MSG_RUN;
          end
          S_MSG_RUN: if (core_done) begin
            en_ed <= 1'b0;
            if (msg_len_r == '0) begin
              en_final <= 1'b1;
              state    <= S_FINAL;
            end else begin
              state <= S_MSG_CAP;
            end
          end
          S_MSG_CAP: begin
            out_reg <= core_data_out;
            m_valid <= 1'b1;
            m_last  <= pos_last;
            state   <= S_MSG_OUT;
          end
          S_MSG_OUT: if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (pos_last) begin
              en_final <= 1'b1;
              state    <= S_FINAL;
            end else begin
              s_ready <= 1'b1;
              state   <= S_MSG_REQ;
            end
          end
          S_FINAL: begin
            en_final  <= 1'b0;
            tag_out   <= core_tag;
            tag_ok    <= dec_r ? (core_tag == exp_tag_r) : 1'b1;
            tag_valid <= 1'b1;
            state     <= S_DONE;
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascon_aead_seq.sv
// Bench for ascon_aead_seq: behavioural core model, block source, output scoreboard and job vector table.
module tb_ascon_aead_seq;

  localparam int LEN_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       cfg_sel_type = '0;
  logic             cfg_decrypt = 1'b0;
  logic [LEN_W-1:0] cfg_ad_len = '0, cfg_msg_len = '0;
  logic [127:0]     cfg_exp_tag = '0;
  logic             s_valid = 1'b0, s_ready;
  logic [127:0]     s_data = '0;
  logic             m_valid, m_ready = 1'b1, m_last;
  logic [127:0]     m_data;
  logic             busy, tag_valid, tag_ok, error;
  logic [127:0]     tag_out;
  logic             core_en_init, core_en_ad, core_en_ed, core_en_final, core_en_hash;
  logic [1:0]       core_sel_type;
  logic             core_mode;
  logic [LEN_W-1:0] core_len, core_pos;
  logic [127:0]     core_data_in, core_tag;
  logic [127:0]     core_data_out = '0;
  logic             core_done, core_err;

  ascon_aead_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_sel_type(cfg_sel_type),
    .cfg_decrypt(cfg_decrypt), .cfg_ad_len(cfg_ad_len), .cfg_msg_len(cfg_msg_len),
    .cfg_exp_tag(cfg_exp_tag), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .tag_valid(tag_valid), .tag_out(tag_out), .tag_ok(tag_ok), .error(error),
    .core_en_init(core_en_init), .core_en_ad(core_en_ad), .core_en_ed(core_en_ed),
    .core_en_final(core_en_final), .core_en_hash(core_en_hash), .core_sel_type(core_sel_type),
    .core_mode(core_mode), .core_len(core_len), .core_pos(core_pos),
    .core_data_in(core_data_in), .core_data_out(core_data_out), .core_tag(core_tag),
    .core_done(core_done), .core_err(core_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ks(input logic [31:0] p);
    return {4{p ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic int nblk(input logic [31:0] len);
    return (len == 0) ? 0 : int'((len + 32'd15) / 32'd16);
  endfunction

  // Core model: each AD/text pass finishes in its 2nd strobe cycle; output registered per pass.
  logic         ad_d = 1'b0, ed_d = 1'b0, err_inject = 1'b0;
  logic [127:0] core_tag_v = '0;
  assign core_done = (core_en_ad & ad_d) | (core_en_ed & ed_d);
  assign core_err  = err_inject & core_en_ad;
  assign core_tag  = core_tag_v;
  always @(posedge clk) begin
    ad_d <= core_en_ad;
    ed_d <= core_en_ed;
    if (core_en_ed) core_data_out <= core_data_in ^ ks(core_pos);
  end

  // Block source.
  logic [127:0] s_q[$];
  logic         s_take;
  int           n_sbeat = 0;
  always begin
    @(negedge clk);
    s_take = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (s_take && s_q.size() > 0) begin
      void'(s_q.pop_front());
      n_sbeat++;
    end
    s_valid = (s_q.size() > 0);
    if (s_valid) s_data = s_q[0];
    else         s_data = '0;
  end

  // Monitor: per-job strobe timeline, pass positions and output scoreboard.
  logic [128:0]     sb[$];
  logic [127:0]     sbm[$];
  logic [LEN_W-1:0] ad_pl[$], msg_pl[$];
  logic [127:0]     ad_dl[$];
  int cyc = 0, f_init, f_ad, f_ed, f_mv, f_fin, f_tv, n_init, n_ad, n_ed, n_fin;
  logic [1:0] sel_seen;
  logic       mode_seen;
  always @(negedge clk) begin
    logic [128:0] e;
    logic [127:0] mk;
    if (start && !busy) begin
      cyc = 0; f_init = -1; f_ad = -1; f_ed = -1; f_mv = -1; f_fin = -1; f_tv = -1;
      n_init = 0; n_ad = 0; n_ed = 0; n_fin = 0;
      ad_pl.delete(); msg_pl.delete(); ad_dl.delete();
    end else begin
      cyc++;
    end
    if (core_en_init)  begin if (f_init < 0) f_init = cyc; n_init++; sel_seen = core_sel_type; end
    if (core_en_ad)    begin if (f_ad < 0) f_ad = cyc; n_ad++; end
    if (core_en_ed)    begin if (f_ed < 0) f_ed = cyc; n_ed++; mode_seen = core_mode; end
    if (core_en_final) begin if (f_fin < 0) f_fin = cyc; n_fin++; end
    if (m_valid && f_mv < 0) f_mv = cyc;
    if (tag_valid && f_tv < 0) f_tv = cyc;
    if (core_en_ad && core_done) begin ad_pl.push_back(core_pos); ad_dl.push_back(core_data_in); end
    if (core_en_ed && core_done) msg_pl.push_back(core_pos);
    if (rst_n && m_valid && m_ready) begin
      chk("m beat expected", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        mk = sbm.pop_front();
        chk("m_data", m_data & mk, e[127:0] & mk);
        chk("m_last", 128'(m_last), 128'(e[128]));
      end
    end
  end

  logic all_outs;
  assign all_outs = |{s_ready, m_valid, m_data, m_last, busy, tag_valid, tag_out, tag_ok, error,
                      core_en_init, core_en_ad, core_en_ed, core_en_final, core_en_hash,
                      core_sel_type, core_mode, core_len, core_pos, core_data_in};

  task automatic load_and_start(input logic [1:0] sel, input logic dec, input logic [31:0] adl,
                                input logic [31:0] msl, input logic match);
    logic [127:0] b, mk;
    int nb;
    for (int k = 0; k < nblk(adl); k++) s_q.push_back({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < nblk(msl); k++) begin
      b  = {$urandom, $urandom, $urandom, $urandom};
      nb = ((msl - 32'(16*k)) >= 32'd16) ? 16 : int'(msl - 32'(16*k));
      mk = '1;
      mk = mk << (8 * (16 - nb));
      s_q.push_back(b);
      sb.push_back({(k == nblk(msl) - 1), b ^ ks(32'(16*k))});
      sbm.push_back(mk);
    end
    core_tag_v = {$urandom, $urandom, $urandom, $urandom};
    n_sbeat = 0;
    @(posedge clk); #1;
    cfg_sel_type = sel;
    cfg_decrypt  = dec;
    cfg_ad_len   = adl;
    cfg_msg_len  = msl;
    cfg_exp_tag  = match ? core_tag_v : ~core_tag_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_tag();
    int t = 0;
    while (!tag_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("tag_valid before timeout", 128'(tag_valid), 128'd1);
  endtask

  task automatic job_checks(input string nm, input logic [1:0] sel, input logic dec,
                            input logic [31:0] adl, input logic [31:0] msl, input logic exp_ok);
    int nad, nms;
    nad = nblk(adl);
    nms = nblk(msl);
    chk({nm, " tag_out"}, tag_out, core_tag_v);
    chk({nm, " tag_ok"}, 128'(tag_ok), 128'(exp_ok));
    chk({nm, " error"}, 128'(error), 128'd0);
    chk({nm, " sel_type"}, 128'(sel_seen), 128'(sel));
    chk({nm, " core_mode"}, 128'(mode_seen), 128'(dec));
    @(negedge clk);
    chk({nm, " busy low after done"}, 128'(busy), 128'd0);
    chk({nm, " tag_valid one cycle"}, 128'(tag_valid), 128'd0);
    chk({nm, " m beats left"}, 128'(sb.size()), 128'd0);
    chk({nm, " s beats consumed"}, 128'(n_sbeat), 128'(nad + nms));
    chk({nm, " ad passes"}, 128'(ad_pl.size()), 128'((nad == 0) ? 1 : nad));
    chk({nm, " msg passes"}, 128'(msg_pl.size()), 128'((nms == 0) ? 1 : nms));
    for (int k = 0; k < ad_pl.size(); k++) chk({nm, " ad pos"}, 128'(ad_pl[k]), 128'(16*k));
    for (int k = 0; k < msg_pl.size(); k++) chk({nm, " msg pos"}, 128'(msg_pl[k]), 128'(16*k));
    if (adl == 0 && ad_dl.size() > 0) chk({nm, " empty AD data"}, ad_dl[0], 128'd0);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        dec;
    logic [31:0] adl;
    logic [31:0] msl;
    logic        match;
    logic        exp_ok;
  } vec_t;

  vec_t vt[5];
  logic [127:0] md;

  initial begin
    vt[0] = '{2'd0, 1'b0, 32'd16, 32'd16, 1'b1, 1'b1};
    vt[1] = '{2'd1, 1'b0, 32'd0,  32'd40, 1'b1, 1'b1};
    vt[2] = '{2'd2, 1'b1, 32'd20, 32'd32, 1'b1, 1'b1};
    vt[3] = '{2'd0, 1'b1, 32'd16, 32'd16, 1'b0, 1'b0};
    vt[4] = '{2'd3, 1'b0, 32'd33, 32'd0,  1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset outputs zero", 128'(all_outs), 128'd0);

    for (int i = 0; i < 5; i++) begin
      load_and_start(vt[i].sel, vt[i].dec, vt[i].adl, vt[i].msl, vt[i].match);
      wait_tag();
      job_checks($sformatf("v%0d", i), vt[i].sel, vt[i].dec, vt[i].adl, vt[i].msl, vt[i].exp_ok);
      if (i == 0) begin
        chk("t1 init cycle", 128'(f_init), 128'd1);
        chk("t1 init count", 128'(n_init), 128'd1);
        chk("t1 ad first", 128'(f_ad), 128'd3);
        chk("t1 ad count", 128'(n_ad), 128'd2);
        chk("t1 ed first", 128'(f_ed), 128'd6);
        chk("t1 ed count", 128'(n_ed), 128'd2);
        chk("t1 m_valid cycle", 128'(f_mv), 128'd9);
        chk("t1 final cycle", 128'(f_fin), 128'd10);
        chk("t1 final count", 128'(n_fin), 128'd1);
        chk("t1 tag_valid cycle", 128'(f_tv), 128'd11);
      end
    end

    // Output stall with an ignored start.
    m_ready = 1'b0;
    load_and_start(2'd0, 1'b0, 32'd16, 32'd32, 1'b1);
    for (int t = 0; t < 100 && !m_valid; t++) @(negedge clk);
    chk("stall m_valid seen", 128'(m_valid), 128'd1);
    md = m_data;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = (k == 1);
      @(negedge clk);
      chk("stall m_data stable", m_data, md);
      chk("stall m_valid held", 128'(m_valid), 128'd1);
      chk("stall strobes low", 128'({core_en_init, core_en_ad, core_en_ed, core_en_final}), 128'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    m_ready = 1'b1;
    wait_tag();
    chk("stall start ignored", 128'(n_init), 128'd1);
    job_checks("stall", 2'd0, 1'b0, 32'd16, 32'd32, 1'b1);
    @(negedge clk);
    chk("stall no second job", 128'(busy), 128'd0);

    // Core error during AD.
    err_inject = 1'b1;
    load_and_start(2'd0, 1'b0, 32'd32, 32'd16, 1'b1);
    wait_tag();
    err_inject = 1'b0;
    chk("err tag_ok", 128'(tag_ok), 128'd0);
    chk("err error set", 128'(error), 128'd1);
    chk("err strobes dropped", 128'({core_en_init, core_en_ad, core_en_ed, core_en_final}), 128'd0);
    @(negedge clk);
    chk("err back to idle", 128'(busy), 128'd0);
    chk("err sticky", 128'(error), 128'd1);
    s_q.delete(); sb.delete(); sbm.delete();
    repeat (2) @(negedge clk);
    load_and_start(2'd1, 1'b0, 32'd16, 32'd16, 1'b1);
    @(negedge clk);
    chk("err cleared by start", 128'(error), 128'd0);
    wait_tag();
    job_checks("after err", 2'd1, 1'b0, 32'd16, 32'd16, 1'b1);

    // Reset in the middle of a text pass.
    load_and_start(2'd0, 1'b0, 32'd16, 32'd32, 1'b1);
    for (int t = 0; t < 100 && !core_en_ed; t++) @(negedge clk);
    chk("rst ed seen", 128'(core_en_ed), 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst outputs zero", 128'(all_outs), 128'd0);
    chk("rst tag_out cleared", tag_out, 128'd0);
    chk("rst no m beat", 128'(sb.size()), 128'd2);
    s_q.delete(); sb.delete(); sbm.delete();
    repeat (2) @(negedge clk);
    load_and_start(2'd2, 1'b1, 32'd16, 32'd16, 1'b1);
    wait_tag();
    job_checks("after rst", 2'd2, 1'b1, 32'd16, 32'd16, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
